// File: rtl/gbc_lcd_transmitter_pkg.sv
// gbc_lcd_transmitter_pkg: GBC screen geometry and frame-buffer word shapes shared by the
// LCD transmitter, the display capture block and the VGA frame-buffer reader.
package gbc_lcd_transmitter_pkg;
  localparam int GBC_W = 160;
  localparam int GBC_H = 144;
  localparam int ADDR_W = 15;
  localparam int PIX_W = 3;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [PIX_W-1:0] pix_t;
  function automatic int slot_cycles(input int dclk_div);
    return 2 * dclk_div;
  endfunction
endpackage

// File: rtl/gbc_slot_timer.sv
// gbc_slot_timer: divides the system clock into LCD slots (LOW phase then HIGH phase);
// each strobe marks the clock edge that ends the current cycle.
module gbc_slot_timer
  import gbc_lcd_transmitter_pkg::*;
#(
  parameter int DCLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic slot_start,
  output logic dclk_rise,
  output logic fetch,
  output logic pre_start
);
  localparam int SLOT = slot_cycles(DCLK_DIV);
  localparam int CW = $clog2(SLOT);
  // the fetch edge sits two cycles ahead of the rise, wrapping into the previous slot when DCLK_DIV=2
  localparam int FETCH = (3 * DCLK_DIV - 3) % SLOT;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (rst || !run || slot_start) ? '0 : cnt + 1'b1;
  always_comb begin
    slot_start = cnt == CW'(SLOT - 1);
    pre_start = cnt == CW'(SLOT - 2);
    dclk_rise = cnt == CW'(DCLK_DIV - 1);
    fetch = cnt == CW'(FETCH);
  end
endmodule

// File: rtl/gbc_lcd_transmitter.sv
// gbc_lcd_transmitter: streams a frame buffer to a GBC-style LCD as slots of dot clock,
// with line-latch and frame-start pulses; every output is a register.
module gbc_lcd_transmitter
  import gbc_lcd_transmitter_pkg::*;
#(
  parameter int H_PIXELS = GBC_W,
  parameter int V_LINES = GBC_H,
  parameter int DCLK_DIV = 4,
  parameter int H_BLANK_SLOTS = 20,
  parameter int V_BLANK_LINES = 10
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  output logic [ADDR_W-1:0] o_pixAddr,
  input  logic [PIX_W-1:0]  i_pixData,
  output logic              o_dclk,
  output logic              o_cls,
  output logic              o_sps,
  output logic [PIX_W-1:0]  o_pixelData,
  output logic              o_frameDone
);
  localparam int LINE_SLOTS = H_PIXELS + 1 + H_BLANK_SLOTS;
  localparam int VB_SLOTS = V_BLANK_LINES * LINE_SLOTS;
  localparam int SW = $clog2(VB_SLOTS + H_PIXELS + H_BLANK_SLOTS + 1);
  localparam int YW = $clog2(V_LINES + 1);
  typedef enum logic [2:0] {IDLE, SYNC, ACTIVE, LATCH, HBLANK, VBLANK} state_t;
  state_t state, state_n;
  logic [SW-1:0] slot, slot_n;
  logic [YW-1:0] y, y_n;
  logic [ADDR_W-1:0] line_base, base_n, addr_n;
  logic [PIX_W-1:0] pix_n;
  logic slot_start, dclk_rise, fetch, pre_start, slot_last;
  logic dclk_n, cls_n, sps_n, done_n;
  gbc_slot_timer #(.DCLK_DIV(DCLK_DIV)) u_timer (
    .clk(i_clk),
    .rst(i_reset),
    .run(state != IDLE),
    .slot_start(slot_start),
    .dclk_rise(dclk_rise),
    .fetch(fetch),
    .pre_start(pre_start)
  );
  always_ff @(posedge i_clk)
    if (i_reset) begin
      state <= IDLE;
      slot <= '0;
      y <= '0;
      line_base <= '0;
      o_pixAddr <= '0;
      o_dclk <= 1'b0;
      o_cls <= 1'b0;
      o_sps <= 1'b0;
      o_pixelData <= '0;
      o_frameDone <= 1'b0;
    end else begin
      state <= state_n;
      slot <= slot_n;
      y <= y_n;
      line_base <= base_n;
      o_pixAddr <= addr_n;
      o_dclk <= dclk_n;
      o_cls <= cls_n;
      o_sps <= sps_n;
      o_pixelData <= pix_n;
      o_frameDone <= done_n;
    end
  // slot counts pixels in ACTIVE and idle slots in HBLANK/VBLANK; SYNC and LATCH are one slot
  always_comb begin
    slot_last = state == ACTIVE ? slot == SW'(H_PIXELS - 1) :
                state == HBLANK ? slot == SW'(H_BLANK_SLOTS - 1) :
                state == VBLANK ? slot == SW'(VB_SLOTS - 1) : 1'b1;
    state_n = state;
    slot_n = slot;
    y_n = y;
    base_n = line_base;
    if (state == IDLE)
      state_n = i_enable ? SYNC : IDLE;
    else if (slot_start) begin
      slot_n = slot_last ? '0 : slot + 1'b1;
      if (slot_last)
        case (state)
          SYNC: state_n = ACTIVE;
          ACTIVE: state_n = LATCH;
          LATCH: state_n = HBLANK;
          HBLANK: begin
            state_n = int'(y) + 1 < V_LINES ? ACTIVE : VBLANK;
            y_n = y + 1'b1;
            base_n = line_base + ADDR_W'(H_PIXELS);
          end
          VBLANK: begin
            state_n = i_enable ? SYNC : IDLE;
            y_n = '0;
            base_n = '0;
          end
          default: state_n = IDLE;
        endcase
    end
  end
  always_comb begin
    sps_n = state_n == SYNC;
    cls_n = state_n == LATCH;
    dclk_n = state == ACTIVE && (dclk_rise || (o_dclk && !slot_start));
    pix_n = state_n != ACTIVE ? '0 : dclk_rise ? i_pixData : o_pixelData;
    addr_n = (state_n == IDLE || state_n == VBLANK) ? '0 :
             (fetch && state_n == ACTIVE) ? base_n + ADDR_W'(slot_n) : o_pixAddr;
    done_n = state == VBLANK && slot_last && pre_start;
  end
endmodule

// File: tb/tb_gbc_lcd_transmitter.sv
// tb_gbc_lcd_transmitter: randomized frame-buffer contents streamed through a reduced-size
// LCD geometry; expected events are queued at stimulus time and matched by a monitor.
module tb_gbc_lcd_transmitter;
  localparam int H = 12;
  localparam int V = 6;
  localparam int D = 3;
  localparam int HB = 3;
  localparam int VB = 2;
  localparam int LINE = H + 1 + HB;
  localparam int F = 2 * D * (1 + (V + VB) * LINE);
  localparam int NPIX = H * V;
  typedef struct {
    int cyc;
    int addr;
    int data;
  } pix_exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [14:0] pix_addr;
  logic [2:0] pix_data = 3'd0;
  logic [2:0] pixel;
  logic dclk, cls, sps, done;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] mem [NPIX];
  int sps_q[$];
  int cls_q[$];
  int done_q[$];
  pix_exp_t pix_q[$];
  pix_exp_t e;
  logic p_dclk = 1'b0, p_cls = 1'b0, p_sps = 1'b0, p_done = 1'b0;
  logic [2:0] p_pix = 3'd0;
  int a1 = 0, a2 = 0, sps_at = 0, cls_at = 0, done_at = 0, ncls = 0;
  int s, rise;

  gbc_lcd_transmitter #(
    .H_PIXELS(H), .V_LINES(V), .DCLK_DIV(D), .H_BLANK_SLOTS(HB), .V_BLANK_LINES(VB)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_enable(en),
    .o_pixAddr(pix_addr),
    .i_pixData(pix_data),
    .o_dclk(dclk),
    .o_cls(cls),
    .o_sps(sps),
    .o_pixelData(pixel),
    .o_frameDone(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    pix_data <= int'(pix_addr) < NPIX ? mem[int'(pix_addr)] : 3'd0;
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event with nothing expected (cycle %0d)", nm, cyc);
  endtask

  task automatic idle_chk(input string nm);
    chk(nm, int'({pix_addr, dclk, cls, sps, pixel, done}), 0);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame of sps at cycle st: SYNC slot, then lines of H pixel slots + latch + HB blank slots.
  task automatic issue_frame(input int st, input int npix, input int nlat, input bit full);
    pix_exp_t x;
    sps_q.push_back(st);
    for (int i = 0; i < npix; i++) begin
      x.cyc = st + 2 * D * (1 + (i / H) * LINE + i % H) + D;
      x.addr = i;
      x.data = int'(mem[i]);
      pix_q.push_back(x);
    end
    for (int l = 0; l < nlat; l++) cls_q.push_back(st + 2 * D * (1 + l * LINE + H));
    if (full) done_q.push_back(st + F - 1);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 3'($urandom);
    wait_until(3);
    rst = 1'b0;
    wait_until(5);
    idle_chk("reset_state");
    wait_until(9);
    en = 1'b1;
    s = 10;
    for (int f = 0; f < 3; f++) issue_frame(s + f * F, NPIX, V, 1'b1);
    wait_until(s + 2 * F + 2 * D * (1 + 2 * LINE));
    en = 1'b0;
    wait_until(s + 3 * F + 4);
    for (int i = 0; i < 4; i++) begin
      idle_chk("idle_after_enable_drop");
      wait_until(cyc + 2);
    end
    en = 1'b1;
    s = cyc + 1;
    rise = s + 2 * D * (1 + 3 * LINE + 7) + D;
    issue_frame(s, 3 * H + 8, 3, 1'b0);
    wait_until(rise + 1);
    rst = 1'b1;
    en = 1'b0;
    wait_until(rise + 2);
    idle_chk("reset_mid_pixel");
    wait_until(rise + 3);
    rst = 1'b0;
    wait_until(rise + 6);
    idle_chk("idle_after_reset");
    wait_until(rise + 10);
    en = 1'b1;
    s = rise + 11;
    issue_frame(s, NPIX, V, 1'b1);
    wait_until(s + 5);
    en = 1'b0;
    wait_until(s + F + 4);
    idle_chk("idle_final");
    chk("sps_left", sps_q.size(), 0);
    chk("pixels_left", pix_q.size(), 0);
    chk("cls_left", cls_q.size(), 0);
    chk("done_left", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial forever begin
    @(negedge clk);
    if (cyc >= 2) begin
      if (sps && !p_sps) begin
        if (sps_q.size() == 0) unexpected("sps");
        else chk("sps_start", cyc, sps_q.pop_front());
        sps_at = cyc;
        ncls = 0;
      end
      if (!sps && p_sps && !rst) chk("sps_width", cyc - sps_at, 2 * D);
      if (dclk && !p_dclk) begin
        if (pix_q.size() == 0) unexpected("dclk_rise");
        else begin
          e = pix_q.pop_front();
          n_cmp++;
          if (cyc != e.cyc || a2 != e.addr || int'(pixel) != e.data) begin
            n_bad++;
            $display("FAIL pixel: cycle %0d addr %0d data %0d, expected cycle %0d addr %0d data %0d",
                     cyc, a2, pixel, e.cyc, e.addr, e.data);
          end
        end
      end
      if (!dclk && p_dclk && !rst && !cls) chk("pixel_hold_at_fall", int'(pixel), int'(p_pix));
      if (cls && !p_cls) begin
        if (cls_q.size() == 0) unexpected("cls");
        else chk("cls_start", cyc, cls_q.pop_front());
        cls_at = cyc;
        ncls++;
      end
      if (!cls && p_cls && !rst) chk("cls_width", cyc - cls_at, 2 * D);
      if (done && !p_done) begin
        if (done_q.size() == 0) unexpected("frame_done");
        else chk("frame_done_cycle", cyc, done_q.pop_front());
        chk("cls_per_frame", ncls, V);
        done_at = cyc;
      end
      if (!done && p_done) chk("frame_done_width", cyc - done_at, 1);
      if (int'(pix_addr) >= NPIX) chk("addr_range", int'(pix_addr), NPIX - 1);
    end
    a2 = a1;
    a1 = int'(pix_addr);
    p_dclk = dclk;
    p_cls = cls;
    p_sps = sps;
    p_done = done;
    p_pix = pixel;
  end
endmodule
